// File: rtl/mdu_stage.sv
`default_nettype none
// ============================================================================
// Module      : mdu_stage
// Description : EX-stage multiply/divide unit. Owns the HI/LO registers,
//               executes MULT/MULTU/DIV/DIVU as a fixed-latency multi-cycle
//               operation and serves MTHI/MTLO in a single cycle.
//
//               The arithmetic itself is combinational and captured into
//               hi_tmp/lo_tmp when the operation is accepted. A countdown then
//               holds busy high for the architectural latency before
//               HI/LO are committed. This gives the hazard controller a
//               realistic stall window.
//
// Ports       : clk    - pipeline clock, rising edge
//               reset  - asynchronous, active-high, clears all state
//               start  - EX holds a valid mult/div/mthi/mtlo this cycle
//               op     - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO,
//                        6/7 no-op
//               A      - forwarded rs value
//               B      - forwarded rt value
//               busy   - long operation in progress (registered)
//               HI     - HI register
//               LO     - LO register
//
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_stage #(
   parameter int MULT_CYCLES = 5,   // busy cycles for MULT/MULTU (1..15)
   parameter int DIV_CYCLES  = 10   // busy cycles for DIV/DIVU   (1..15)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   state_t      state_q,  state_d;
   logic [3:0]  cnt_q,    cnt_d;
   logic        busy_q,   busy_d;
   logic [31:0] hi_q,     hi_d;
   logic [31:0] lo_q,     lo_d;
   logic [31:0] hi_tmp_q, hi_tmp_d;
   logic [31:0] lo_tmp_q, lo_tmp_d;

   // ------------------------------------------------------------------------
   // Multiplier datapath
   // ------------------------------------------------------------------------
   // Sign- or zero-extending to 64 bits first makes the low 64 bits of a
   // plain unsigned product equal to the signed/unsigned 64-bit result.
   logic [63:0] w_a_sext, w_b_sext;
   logic [63:0] w_a_zext, w_b_zext;
   logic [63:0] w_prod_s, w_prod_u;

   always_comb begin
      w_a_sext = {{32{A[31]}}, A};
      w_b_sext = {{32{B[31]}}, B};
      w_a_zext = {32'd0, A};
      w_b_zext = {32'd0, B};
      w_prod_s = w_a_sext * w_b_sext;
      w_prod_u = w_a_zext * w_b_zext;
   end

   // ------------------------------------------------------------------------
   // Divider datapath
   // ------------------------------------------------------------------------
   // Signed division works on magnitudes and fixes up the signs afterwards.
   // The magnitude of 0x80000000 is 2^31, which still fits in 32 unsigned
   // bits, so 0x80000000 / -1 wraps naturally to 0x80000000 with a zero
   // remainder instead of hitting a signed-overflow corner case.
   logic        w_b_zero;
   logic [31:0] w_abs_a, w_abs_b, w_abs_b_safe, w_b_safe;
   logic [31:0] w_quo_mag, w_rem_mag;
   logic [31:0] w_quo_s, w_rem_s;
   logic [31:0] w_quo_u, w_rem_u;
   logic        w_quo_neg;

   always_comb begin
      w_b_zero     = (B == 32'd0);
      w_abs_a      = A[31] ? (~A + 32'd1) : A;
      w_abs_b      = B[31] ? (~B + 32'd1) : B;
      // Divide-by-zero results are discarded; substitute 1 so the divider
      // never sees a zero divisor.
      w_abs_b_safe = w_b_zero ? 32'd1 : w_abs_b;
      w_b_safe     = w_b_zero ? 32'd1 : B;

      w_quo_mag    = w_abs_a / w_abs_b_safe;
      w_rem_mag    = w_abs_a % w_abs_b_safe;
      w_quo_neg    = A[31] ^ B[31];
      w_quo_s      = w_quo_neg ? (~w_quo_mag + 32'd1) : w_quo_mag;
      // Remainder follows the dividend's sign.
      w_rem_s      = A[31] ? (~w_rem_mag + 32'd1) : w_rem_mag;

      w_quo_u      = A / w_b_safe;
      w_rem_u      = A % w_b_safe;
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      hi_tmp_d = hi_tmp_q;
      lo_tmp_d = lo_tmp_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               case (op)
                  OP_MULT: begin
                     hi_tmp_d = w_prod_s[63:32];
                     lo_tmp_d = w_prod_s[31:0];
                     cnt_d    = MULT_CNT;
                     state_d  = S_RUN;
                  end
                  OP_MULTU: begin
                     hi_tmp_d = w_prod_u[63:32];
                     lo_tmp_d = w_prod_u[31:0];
                     cnt_d    = MULT_CNT;
                     state_d  = S_RUN;
                  end
                  OP_DIV: begin
                     // On divide by zero the temps take the current HI/LO
                     // so the final commit leaves them unchanged.
                     hi_tmp_d = w_b_zero ? hi_q : w_rem_s;
                     lo_tmp_d = w_b_zero ? lo_q : w_quo_s;
                     cnt_d    = DIV_CNT;
                     state_d  = S_RUN;
                  end
                  OP_DIVU: begin
                     hi_tmp_d = w_b_zero ? hi_q : w_rem_u;
                     lo_tmp_d = w_b_zero ? lo_q : w_quo_u;
                     cnt_d    = DIV_CNT;
                     state_d  = S_RUN;
                  end
                  OP_MTHI: hi_d = A;
                  OP_MTLO: lo_d = A;
                  default: ; // 6/7 are no-ops
               endcase
            end
         end

         S_RUN: begin
            // Any start arriving here is ignored.
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               hi_d    = hi_tmp_q;
               lo_d    = lo_tmp_q;
               state_d = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d == S_RUN);
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= 4'd0;
         busy_q   <= 1'b0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
         hi_tmp_q <= 32'd0;
         lo_tmp_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         hi_tmp_q <= hi_tmp_d;
         lo_tmp_q <= lo_tmp_d;
      end
   end

   assign busy = busy_q;
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_stage
// Description : Directed testbench for mdu_stage. Each scenario task drives
//               its own stimulus and compares outputs against hand-computed
//               values. Inputs change and outputs are sampled on the
//               falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_stage;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a_in;
   logic [31:0] b_in;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   int vectors;
   int miscompares;

   mdu_stage #(
      .MULT_CYCLES (5),
      .DIV_CYCLES  (10)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .A     (a_in),
      .B     (b_in),
      .busy  (busy),
      .HI    (hi),
      .LO    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one instruction for one cycle. Returns at the falling edge of
   // the first cycle after the accepting edge.
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start = 1'b1;
      op    = o;
      a_in  = a;
      b_in  = b;
      @(negedge clk);
      start = 1'b0;
      op    = 3'd7;
   endtask

   // Count cycles while busy stays high (bounded). Returns at the falling
   // edge of the first cycle with busy low.
   task automatic wait_idle(output int n);
      n = 0;
      while (busy === 1'b1 && n < 40) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      start = 1'b0;
      op    = 3'd7;
      a_in  = 32'd0;
      b_in  = 32'd0;
      repeat (2) @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_state: busy=%b HI=%h LO=%h, expected busy=0 HI=0 LO=0", busy, hi, lo);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_mtlo;
      issue(3'd5, 32'h0000_1234, 32'd0);
      vectors++;
      if (lo !== 32'h0000_1234 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL mtlo: LO=%h busy=%b, expected LO=00001234 busy=0", lo, busy);
      end
      issue(3'd4, 32'h0000_5678, 32'd0);
      vectors++;
      if (hi !== 32'h0000_5678 || busy !== 1'b0 || lo !== 32'h0000_1234) begin
         miscompares++;
         $display("FAIL mthi: HI=%h LO=%h busy=%b, expected HI=00005678 LO=00001234 busy=0", hi, lo, busy);
      end
      issue(3'd6, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      vectors++;
      if (hi !== 32'h0000_5678 || lo !== 32'h0000_1234 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL noop: HI=%h LO=%h busy=%b, expected HI=00005678 LO=00001234 busy=0", hi, lo, busy);
      end
   endtask

   task automatic test_mult;
      int n;
      // HI/LO currently 5678/1234 from test_mtlo; they must hold during RUN.
      issue(3'd0, 32'hFFFF_FFFD, 32'd5);
      vectors++;
      if (busy !== 1'b1 || hi !== 32'h0000_5678 || lo !== 32'h0000_1234) begin
         miscompares++;
         $display("FAIL mult_hold: busy=%b HI=%h LO=%h, expected busy=1 HI=00005678 LO=00001234", busy, hi, lo);
      end
      wait_idle(n);
      vectors++;
      if (n != 5 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin
         miscompares++;
         $display("FAIL mult_signed: cycles=%0d HI=%h LO=%h, expected cycles=5 HI=ffffffff LO=fffffff1", n, hi, lo);
      end
      issue(3'd1, 32'hFFFF_FFFF, 32'd2);
      wait_idle(n);
      vectors++;
      if (n != 5 || hi !== 32'h0000_0001 || lo !== 32'hFFFF_FFFE) begin
         miscompares++;
         $display("FAIL multu: cycles=%0d HI=%h LO=%h, expected cycles=5 HI=00000001 LO=fffffffe", n, hi, lo);
      end
   endtask

   task automatic test_div;
      int n;
      issue(3'd2, 32'hFFFF_FFF9, 32'd2);
      wait_idle(n);
      vectors++;
      if (n != 10 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
         miscompares++;
         $display("FAIL div_signed: cycles=%0d HI=%h LO=%h, expected cycles=10 HI=ffffffff LO=fffffffd", n, hi, lo);
      end
      issue(3'd3, 32'd7, 32'd2);
      wait_idle(n);
      vectors++;
      if (n != 10 || hi !== 32'd1 || lo !== 32'd3) begin
         miscompares++;
         $display("FAIL divu: cycles=%0d HI=%h LO=%h, expected cycles=10 HI=00000001 LO=00000003", n, hi, lo);
      end
      issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle(n);
      vectors++;
      if (n != 10 || hi !== 32'd0 || lo !== 32'h8000_0000) begin
         miscompares++;
         $display("FAIL div_overflow: cycles=%0d HI=%h LO=%h, expected cycles=10 HI=00000000 LO=80000000", n, hi, lo);
      end
      // Signed divide with negative divisor: 7 / -2 = -3 rem 1
      issue(3'd2, 32'd7, 32'hFFFF_FFFE);
      wait_idle(n);
      vectors++;
      if (hi !== 32'd1 || lo !== 32'hFFFF_FFFD) begin
         miscompares++;
         $display("FAIL div_neg_divisor: HI=%h LO=%h, expected HI=00000001 LO=fffffffd", hi, lo);
      end
   endtask

   task automatic test_div_by_zero;
      int n;
      issue(3'd4, 32'h0000_0011, 32'd0);
      issue(3'd5, 32'h0000_0022, 32'd0);
      issue(3'd3, 32'd5, 32'd0);
      wait_idle(n);
      vectors++;
      if (n != 10 || hi !== 32'h0000_0011 || lo !== 32'h0000_0022) begin
         miscompares++;
         $display("FAIL divu_by_zero: cycles=%0d HI=%h LO=%h, expected cycles=10 HI=00000011 LO=00000022", n, hi, lo);
      end
      issue(3'd2, 32'hFFFF_FFF9, 32'd0);
      wait_idle(n);
      vectors++;
      if (n != 10 || hi !== 32'h0000_0011 || lo !== 32'h0000_0022) begin
         miscompares++;
         $display("FAIL div_by_zero: cycles=%0d HI=%h LO=%h, expected cycles=10 HI=00000011 LO=00000022", n, hi, lo);
      end
   endtask

   task automatic test_ignore_in_run;
      int n;
      issue(3'd0, 32'd6, 32'd7);
      // Busy cycle 1: offer MTHI, busy cycle 2: offer MTLO, both must be dropped.
      start = 1'b1;
      op    = 3'd4;
      a_in  = 32'h0000_AAAA;
      @(negedge clk);
      op    = 3'd5;
      a_in  = 32'h0000_BBBB;
      @(negedge clk);
      start = 1'b0;
      op    = 3'd7;
      vectors++;
      if (hi !== 32'h0000_0011 || lo !== 32'h0000_0022 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL ignore_hold: HI=%h LO=%h busy=%b, expected HI=00000011 LO=00000022 busy=1", hi, lo, busy);
      end
      wait_idle(n);
      vectors++;
      if (n + 2 != 5 || hi !== 32'd0 || lo !== 32'd42) begin
         miscompares++;
         $display("FAIL ignore_in_run: cycles=%0d HI=%h LO=%h, expected cycles=5 HI=00000000 LO=0000002a", n + 2, hi, lo);
      end
   endtask

   task automatic test_back_to_back;
      int n;
      issue(3'd0, 32'd3, 32'd4);
      wait_idle(n);
      vectors++;
      if (n != 5 || hi !== 32'd0 || lo !== 32'd12) begin
         miscompares++;
         $display("FAIL b2b_mult: cycles=%0d HI=%h LO=%h, expected cycles=5 HI=00000000 LO=0000000c", n, hi, lo);
      end
      // Same cycle busy first reads 0: present DIV 100 / 7.
      start = 1'b1;
      op    = 3'd2;
      a_in  = 32'd100;
      b_in  = 32'd7;
      @(negedge clk);
      start = 1'b0;
      op    = 3'd7;
      vectors++;
      if (busy !== 1'b1 || lo !== 32'd12) begin
         miscompares++;
         $display("FAIL b2b_accept: busy=%b LO=%h, expected busy=1 LO=0000000c", busy, lo);
      end
      wait_idle(n);
      vectors++;
      if (n != 10 || hi !== 32'd2 || lo !== 32'd14) begin
         miscompares++;
         $display("FAIL b2b_div: cycles=%0d HI=%h LO=%h, expected cycles=10 HI=00000002 LO=0000000e", n, hi, lo);
      end
   endtask

   task automatic test_reset_mid_run;
      int n;
      issue(3'd4, 32'h0000_0055, 32'd0);
      issue(3'd2, 32'd9, 32'd2);
      // Now in busy cycle 1; advance to busy cycle 3.
      repeat (2) @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      vectors++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_mid_run: busy=%b HI=%h LO=%h, expected busy=0 HI=0 LO=0", busy, hi, lo);
      end
      @(negedge clk);
      reset = 1'b0;
      issue(3'd1, 32'd3, 32'd4);
      wait_idle(n);
      vectors++;
      if (n != 5 || hi !== 32'd0 || lo !== 32'd12) begin
         miscompares++;
         $display("FAIL after_reset: cycles=%0d HI=%h LO=%h, expected cycles=5 HI=00000000 LO=0000000c", n, hi, lo);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset;
      test_mtlo;
      test_mult;
      test_div;
      test_div_by_zero;
      test_ignore_in_run;
      test_back_to_back;
      test_reset_mid_run;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
